// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Bootloader for the toy CPU. It takes a framed byte stream over a
// valid/ready handshake and turns it into 16-bit instruction words, which it
// writes into the CPU's code memory. The CPU is held in reset until a load
// finishes with a matching checksum.
//
// Frame on the wire: LEN (N words), then 2N data bytes with the high byte of
// each word first, then CHK. CHK is the mod-256 sum of the data bytes only.
//
// Ports
//   clk           system clock; all state changes happen on the rising edge
//   rst_n         synchronous active-low reset
//   start         one-cycle load request; honoured in IDLE, DONE and ERR
//   in_data       incoming byte
//   in_valid      in_data holds a valid byte
//   in_ready      loader accepts a byte this cycle (depends on state only)
//   prog_addr     code memory write address
//   prog_data     code memory write data (first byte of the pair in [15:8])
//   prog_we       one-cycle code memory write strobe
//   cpu_reset     active-high reset to the CPU; low only in DONE
//   load_done     last load completed with a good checksum
//   load_err      last load aborted (bad length or checksum mismatch)
//   words_loaded  number of words written in the current or last load
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              prog_we,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int         LEN_W   = ADDR_W + 1;
    localparam logic [8:0] MAX_LEN = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_q, we_d;
    logic                ready_q, ready_d;
    logic                cpuRst_q, cpuRst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [LEN_W-1:0]    words_q, words_d;

    logic                accept;
    logic                lenOk;
    logic                lastWord;

    // A byte moves only when the registered ready meets valid, so ready can
    // never combinationally follow in_valid.
    assign accept   = in_valid & ready_q;
    assign lenOk    = (in_data != 8'd0) && ({1'b0, in_data} <= MAX_LEN);
    assign lastWord = ({1'b0, index_q} == (len_q - LEN_W'(1)));

    // Next-state and datapath updates. Every output is registered: the flag
    // outputs are decoded from the next state so they line up with the state
    // register, and the write strobe is raised on the edge that enters WRITE
    // so it is high for exactly the WRITE cycle.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        len_d   = len_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        words_d = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    index_d = '0;
                    sum_d   = 8'd0;
                    words_d = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (lenOk) begin
                        len_d   = LEN_W'(in_data);
                        state_d = S_HI;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    data_d[DATA_W-1:8] = in_data;
                    sum_d              = sum_q + in_data;
                    state_d            = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    data_d[7:0] = in_data;
                    sum_d       = sum_q + in_data;
                    addr_d      = index_q;
                    we_d        = 1'b1;
                    words_d     = words_q + LEN_W'(1);
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // Length is capped at DEPTH, so the index stops at DEPTH-1
                // and the address can never wrap.
                if (lastWord) begin
                    state_d = S_CHK;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d  = (state_d == S_LEN) || (state_d == S_HI) ||
                   (state_d == S_LO)  || (state_d == S_CHK);
        cpuRst_d = (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
    end

    // State register with synchronous active-low reset. Reset beats every
    // other event, including a byte transfer or a start on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            len_q    <= '0;
            sum_q    <= 8'd0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            cpuRst_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            len_q    <= len_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            ready_q  <= ready_d;
            cpuRst_q <= cpuRst_d;
            done_q   <= done_d;
            err_q    <= err_d;
            words_q  <= words_d;
        end
    end

    assign in_ready     = ready_q;
    assign prog_addr    = addr_q;
    assign prog_data    = data_q;
    assign prog_we      = we_q;
    assign cpu_reset    = cpuRst_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule
